ps2_command_tx: RTL



---
 rtl/ps2_command_tx.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_command_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 8 data bits,
// odd parity, stop, then checks the device acknowledge.
module ps2_command_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, DATA, STOP, ACK, WAIT_IDLE
  } state_t;

  state_t        state, state_n;
  logic          clk_s1, clk_s2, clk_prev;
  logic          dat_s1, dat_s2;
  logic          fall;
  logic [7:0]    shift, shift_n;
  logic          parity, parity_n;
  logic [3:0]    idx, idx_n;
  logic [IW-1:0] icnt, icnt_n;
  logic [CW-1:0] tcnt, tcnt_n;
  logic          clk_oe, clk_oe_n;
  logic          dat_oe, dat_oe_n;
  logic          done, done_n;
  logic          err, err_n;

  assign tx_ready   = (state == IDLE) & ~done & ~err;
  assign tx_done    = done;
  assign tx_error   = err;
  assign ps2_clk_oe = clk_oe;
  assign ps2_dat_oe = dat_oe;

  // two-flop synchronizers plus a registered falling-edge strobe
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      fall     <= 1'b0;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_dat_in;
      dat_s2   <= dat_s1;
      fall     <= clk_prev & ~clk_s2;
    end
  end

  // state, datapath and registered line/pulse outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      shift  <= '0;
      parity <= 1'b0;
      idx    <= '0;
      icnt   <= '0;
      tcnt   <= '0;
      clk_oe <= 1'b0;
      dat_oe <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      shift  <= shift_n;
      parity <= parity_n;
      idx    <= idx_n;
      icnt   <= icnt_n;
      tcnt   <= tcnt_n;
      clk_oe <= clk_oe_n;
      dat_oe <= dat_oe_n;
      done   <= done_n;
      err    <= err_n;
    end
  end

  // next-state logic; the timeout check overrides any same-cycle fall
  always_comb begin
    state_n  = state;
    shift_n  = shift;
    parity_n = parity;
    idx_n    = idx;
    icnt_n   = icnt;
    tcnt_n   = tcnt;
    clk_oe_n = clk_oe;
    dat_oe_n = dat_oe;
    done_n   = 1'b0;
    err_n    = 1'b0;
    if (state == IDLE) begin
      tcnt_n   = '0;
      icnt_n   = '0;
      clk_oe_n = 1'b0;
      dat_oe_n = 1'b0;
      if (tx_valid && tx_ready) begin
        shift_n  = tx_data;
        parity_n = ~^tx_data;
        idx_n    = '0;
        clk_oe_n = 1'b1;
        state_n  = INHIBIT;
      end
    end else if (tcnt == CW'(TIMEOUT_CYCLES - 1)) begin
      clk_oe_n = 1'b0;
      dat_oe_n = 1'b0;
      err_n    = 1'b1;
      state_n  = IDLE;
    end else begin
      tcnt_n = tcnt + 1'b1;
      unique case (state)
        INHIBIT: begin
          if (icnt == IW'(INHIBIT_CYCLES - 1)) begin
            clk_oe_n = 1'b0;
            dat_oe_n = 1'b1;
            state_n  = RTS;
          end else begin
            icnt_n = icnt + 1'b1;
          end
        end
        RTS: begin
          if (fall) begin
            dat_oe_n = ~shift[0];
            shift_n  = {1'b0, shift[7:1]};
            idx_n    = 4'd1;
            state_n  = DATA;
          end
        end
        DATA: begin
          if (fall) begin
            if (idx == 4'd8) begin
              dat_oe_n = ~parity;
              state_n  = STOP;
            end else begin
              dat_oe_n = ~shift[0];
              shift_n  = {1'b0, shift[7:1]};
              idx_n    = idx + 1'b1;
            end
          end
        end
        STOP: begin
          if (fall) begin
            dat_oe_n = 1'b0;
            state_n  = ACK;
          end
        end
        ACK: begin
          if (fall) begin
            if (dat_s2) begin
              err_n   = 1'b1;
              state_n = IDLE;
            end else begin
              state_n = WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          if (clk_s2 && dat_s2) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule
